pipelined_adder_dut: RTL

Parametrised successor of the single-shot adder DUT. It is a WIDTH-bit add/subtract unit behind a fully pipelined valid/ready input and output. It accepts one operation per cycle, holds up to STAGES operations in flight, and supports back-pressure without losing or duplicating data. It sits between the UVM-style driver interface and the monitor/scoreboard in the lab testbench.

---
 rtl/pipelined_adder_dut.sv | 90 +++++++++
 1 files changed

// File: rtl/pipelined_adder_dut.sv
// pipelined_adder_dut: valid/ready pipelined add/sub unit; define ADDER_SAT_EN to add the saturating 'sat' mode input
module pipelined_adder_dut #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic                         in_op,
`ifdef ADDER_SAT_EN
  input  logic                         sat,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_sum,
  output logic                         out_carry,
  output logic                         out_ovf,
  output logic [$clog2(STAGES+1)-1:0]  in_flight
);
  localparam int CW = $clog2(STAGES+1);
  logic [STAGES-1:0] v_q, v_d, en, carry_q, carry_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [CW-1:0]     in_flight_q, in_flight_d;
  logic [WIDTH-1:0]  b_eff, res;
  logic [WIDTH:0]    raw;
  logic              ovf_raw, free;
  // stage-1 arithmetic: subtraction as A + ~B + 1, overflow from operand/result signs
  always_comb begin
    b_eff   = in_op ? ~in_b : in_b;
    raw     = {1'b0, in_a} + {1'b0, b_eff} + (WIDTH+1)'(in_op);
    ovf_raw = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != in_a[WIDTH-1]);
`ifdef ADDER_SAT_EN
    res     = (sat && ovf_raw) ? {in_a[WIDTH-1], {(WIDTH-1){~in_a[WIDTH-1]}}} : raw[WIDTH-1:0];
`else
    res     = raw[WIDTH-1:0];
`endif
  end
  // a stage may load when it, or any stage downstream of it, is empty or the output drains
  always_comb begin
    free = out_ready;
    en   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      free  = free || !v_q[k];
      en[k] = free;
    end
  end
  // shift the pipeline; data registers only load alongside a valid bit so no X enters
  always_comb begin
    v_d        = en[0] ? {v_q[STAGES-1:1], in_valid} : v_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    sum_d[0]   = (en[0] && in_valid) ? res : sum_q[0];
    carry_d[0] = (en[0] && in_valid) ? raw[WIDTH] : carry_q[0];
    ovf_d[0]   = (en[0] && in_valid) ? ovf_raw : ovf_q[0];
    for (int k = 1; k < STAGES; k++) begin
      v_d[k]     = en[k] ? v_q[k-1] : v_q[k];
      sum_d[k]   = (en[k] && v_q[k-1]) ? sum_q[k-1] : sum_q[k];
      carry_d[k] = (en[k] && v_q[k-1]) ? carry_q[k-1] : carry_q[k];
      ovf_d[k]   = (en[k] && v_q[k-1]) ? ovf_q[k-1] : ovf_q[k];
    end
    in_flight_d = in_flight_q + CW'(in_valid && en[0]) - CW'(v_q[STAGES-1] && out_ready);
  end
  // pipeline state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q         <= '0;
      carry_q     <= '0;
      ovf_q       <= '0;
      sum_q       <= '{default: '0};
      in_flight_q <= '0;
    end else begin
      v_q         <= v_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      sum_q       <= sum_d;
      in_flight_q <= in_flight_d;
    end
  end
  assign in_ready  = en[0];
  assign out_valid = v_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_carry = carry_q[STAGES-1];
  assign out_ovf   = ovf_q[STAGES-1];
  assign in_flight = in_flight_q;
endmodule
